// File: rtl/decode_ex_pipe_if.sv
// -----------------------------------------------------------------------------
// decode_ex_pipe_if
// Bundle of every signal crossing the ID/EX boundary of the RIDA CPU:
//   - decode side   : in_valid/in_ready handshake, flush, decoded control and
//                     operands (*_d), source/dest addresses and use flags
//   - write-back    : regwrite_w / rdw / result_w, used for operand bypass
//   - execute side  : out_valid/out_ready handshake, registered control and
//                     operands (*_e), register addresses, stall counter
// Modports:
//   slave  - the pipeline stage itself
//   master - the environment around it (decode, write-back, execute)
// -----------------------------------------------------------------------------
interface decode_ex_pipe_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4,
   parameter int ALUC_W = 3,
   parameter int CNT_W  = 16
);
   // decode side
   logic              in_valid;
   logic              in_ready;
   logic              flush;
   logic              regwrite_d, alusrc_d, memwrite_d, resultsrc_d, branch_d;
   logic [ALUC_W-1:0] alucontrol_d;
   logic              use_rn_d, use_rd_d;
   logic [DATA_W-1:0] rd1_d, rd2_d, imm_d, pc_d, pcplus4_d;
   logic [REG_AW-1:0] rn_d, rd_d;
   // write-back
   logic              regwrite_w;
   logic [REG_AW-1:0] rdw;
   logic [DATA_W-1:0] result_w;
   // execute side
   logic              out_valid;
   logic              out_ready;
   logic              regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e;
   logic [ALUC_W-1:0] alucontrol_e;
   logic [DATA_W-1:0] rd1_e, rd2_e, imm_e, pc_e, pcplus4_e;
   logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
   logic [CNT_W-1:0]  stall_cnt;

   modport slave (
      input  in_valid, flush,
      input  regwrite_d, alusrc_d, memwrite_d, resultsrc_d, branch_d, alucontrol_d,
      input  use_rn_d, use_rd_d, rd1_d, rd2_d, imm_d, pc_d, pcplus4_d, rn_d, rd_d,
      input  regwrite_w, rdw, result_w,
      input  out_ready,
      output in_ready, out_valid,
      output regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e, alucontrol_e,
      output rd1_e, rd2_e, imm_e, pc_e, pcplus4_e, rs1_e, rs2_e, rd_e,
      output stall_cnt
   );

   modport master (
      output in_valid, flush,
      output regwrite_d, alusrc_d, memwrite_d, resultsrc_d, branch_d, alucontrol_d,
      output use_rn_d, use_rd_d, rd1_d, rd2_d, imm_d, pc_d, pcplus4_d, rn_d, rd_d,
      output regwrite_w, rdw, result_w,
      output out_ready,
      input  in_ready, out_valid,
      input  regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e, alucontrol_e,
      input  rd1_e, rd2_e, imm_e, pc_e, pcplus4_e, rs1_e, rs2_e, rd_e,
      input  stall_cnt
   );
endinterface

// File: rtl/decode_ex_pipe.sv
// -----------------------------------------------------------------------------
// decode_ex_pipe
// ID/EX pipeline register for the RIDA CPU with valid/ready backpressure,
// synchronous flush, write-back bypass on operand capture and load-use hazard
// detection (one bubble per hazard, counted in a saturating stall counter).
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset, clears all state
//   bus  - decode_ex_pipe_if.slave: decode inputs, write-back bypass inputs,
//          execute outputs and the stall counter
// Latency 1 cycle, throughput 1 instruction/cycle when no hazard is present.
// -----------------------------------------------------------------------------
module decode_ex_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4,
   parameter int ALUC_W = 3,
   parameter int CNT_W  = 16
) (
   input logic            clk,
   input logic            rst,
   decode_ex_pipe_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic              regwrite;
      logic              alusrc;
      logic              memwrite;
      logic              resultsrc;
      logic              branch;
      logic [ALUC_W-1:0] aluc;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] pcplus4;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
   } ex_pkt_t;

   ex_pkt_t          pkt_q, pkt_d, pkt_in;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_en, hazard;

   // The stage can take a new entry when execute drains it or it is empty.
   assign load_en = bus.out_ready | ~valid_q;

   // A load in execute whose destination decode wants to read.
   assign hazard = bus.in_valid & valid_q & pkt_q.regwrite & pkt_q.resultsrc &
                   ((bus.use_rn_d & (pkt_q.rd == bus.rn_d)) |
                    (bus.use_rd_d & (pkt_q.rd == bus.rd_d)));

   // Flush always consumes (and discards) whatever decode presents.
   assign bus.in_ready = bus.flush | (load_en & ~hazard);

   // Incoming packet; operands bypass the register file write happening in
   // the same cycle so the captured value is never stale.
   always_comb begin
      pkt_in           = '0;
      pkt_in.regwrite  = bus.regwrite_d;
      pkt_in.alusrc    = bus.alusrc_d;
      pkt_in.memwrite  = bus.memwrite_d;
      pkt_in.resultsrc = bus.resultsrc_d;
      pkt_in.branch    = bus.branch_d;
      pkt_in.aluc      = bus.alucontrol_d;
      pkt_in.rd1       = (bus.regwrite_w & (bus.rdw == bus.rn_d)) ? bus.result_w : bus.rd1_d;
      pkt_in.rd2       = (bus.regwrite_w & (bus.rdw == bus.rd_d)) ? bus.result_w : bus.rd2_d;
      pkt_in.imm       = bus.imm_d;
      pkt_in.pc        = bus.pc_d;
      pkt_in.pcplus4   = bus.pcplus4_d;
      pkt_in.rs1       = bus.rn_d;
      pkt_in.rs2       = bus.rd_d;
      pkt_in.rd        = bus.rd_d;
   end

   // Next-state selection in priority order: flush, bubble, capture, drain,
   // hold. Bubble and drain only clear valid; the payload is left in place.
   always_comb begin
      valid_d = valid_q;
      pkt_d   = pkt_q;
      cnt_d   = cnt_q;
      if (bus.flush) begin
         valid_d = 1'b0;
      end else if (load_en && hazard) begin
         valid_d = 1'b0;
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (load_en && bus.in_valid) begin
         valid_d = 1'b1;
         pkt_d   = pkt_in;
      end else if (load_en) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         pkt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pkt_q   <= pkt_d;
         cnt_q   <= cnt_d;
      end
   end

   // Side-effecting controls are masked by valid so bubbles and flushed
   // slots are harmless; the stored bits stay intact underneath.
   assign bus.out_valid    = valid_q;
   assign bus.regwrite_e   = pkt_q.regwrite & valid_q;
   assign bus.memwrite_e   = pkt_q.memwrite & valid_q;
   assign bus.branch_e     = pkt_q.branch   & valid_q;
   assign bus.alusrc_e     = pkt_q.alusrc;
   assign bus.resultsrc_e  = pkt_q.resultsrc;
   assign bus.alucontrol_e = pkt_q.aluc;
   assign bus.rd1_e        = pkt_q.rd1;
   assign bus.rd2_e        = pkt_q.rd2;
   assign bus.imm_e        = pkt_q.imm;
   assign bus.pc_e         = pkt_q.pc;
   assign bus.pcplus4_e    = pkt_q.pcplus4;
   assign bus.rs1_e        = pkt_q.rs1;
   assign bus.rs2_e        = pkt_q.rs2;
   assign bus.rd_e         = pkt_q.rd;
   assign bus.stall_cnt    = cnt_q;

endmodule

// File: tb/tb_decode_ex_pipe.sv
module tb_decode_ex_pipe;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  decode_ex_pipe_if #(.DATA_W(32), .REG_AW(4), .ALUC_W(3), .CNT_W(2)) bus ();

  decode_ex_pipe #(.DATA_W(32), .REG_AW(4), .ALUC_W(3), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic rw, input logic rs, input logic mw,
                           input logic urn, input logic urd,
                           input logic [3:0] rn, input logic [3:0] rd,
                           input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] pc);
    bus.in_valid     = 1'b1;
    bus.regwrite_d   = rw;
    bus.resultsrc_d  = rs;
    bus.memwrite_d   = mw;
    bus.alusrc_d     = 1'b0;
    bus.branch_d     = 1'b0;
    bus.alucontrol_d = 3'd2;
    bus.use_rn_d     = urn;
    bus.use_rd_d     = urd;
    bus.rn_d         = rn;
    bus.rd_d         = rd;
    bus.rd1_d        = rd1;
    bus.rd2_d        = rd2;
    bus.imm_d        = pc + 32'd8;
    bus.pc_d         = pc;
    bus.pcplus4_d    = pc + 32'd4;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus.regwrite_d = 1'b0; bus.alusrc_d = 1'b0; bus.memwrite_d = 1'b0;
    bus.resultsrc_d = 1'b0; bus.branch_d = 1'b0; bus.alucontrol_d = '0;
    bus.use_rn_d = 1'b0; bus.use_rd_d = 1'b0;
    bus.rd1_d = '0; bus.rd2_d = '0; bus.imm_d = '0; bus.pc_d = '0; bus.pcplus4_d = '0;
    bus.rn_d = '0; bus.rd_d = '0;
    bus.regwrite_w = 1'b0; bus.rdw = '0; bus.result_w = '0;

    #12;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_stall_cnt", bus.stall_cnt, 2'd0);
    chk("rst_rd1_e", bus.rd1_e, 32'h0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    rst = 1'b1;
    tick();

    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 4'd3, 32'h11, 32'h22, 32'h100);
    #1 chk("add_in_ready", bus.in_ready, 1'b1);
    tick();
    chk("add_out_valid", bus.out_valid, 1'b1);
    chk("add_rd1_e", bus.rd1_e, 32'h11);
    chk("add_rd2_e", bus.rd2_e, 32'h22);
    chk("add_rs1_e", bus.rs1_e, 4'd2);
    chk("add_rd_e", bus.rd_e, 4'd3);
    chk("add_regwrite_e", bus.regwrite_e, 1'b1);
    chk("add_pcplus4_e", bus.pcplus4_e, 32'h104);

    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 4'd5, 32'h40, 32'h0, 32'h104);
    #1 chk("ld_in_ready", bus.in_ready, 1'b1);
    tick();
    chk("ld_out_valid", bus.out_valid, 1'b1);
    chk("ld_resultsrc_e", bus.resultsrc_e, 1'b1);
    chk("ld_rd_e", bus.rd_e, 4'd5);
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd6, 32'h55, 32'h66, 32'h108);
    #1 chk("hz_in_ready", bus.in_ready, 1'b0);
    tick();
    chk("bub_out_valid", bus.out_valid, 1'b0);
    chk("bub_regwrite_e", bus.regwrite_e, 1'b0);
    chk("bub_stall_cnt", bus.stall_cnt, 2'd1);
    chk("bub_in_ready", bus.in_ready, 1'b1);
    tick();
    chk("use_out_valid", bus.out_valid, 1'b1);
    chk("use_rd_e", bus.rd_e, 4'd6);
    chk("use_rs1_e", bus.rs1_e, 4'd5);
    chk("use_rd1_e", bus.rd1_e, 32'h55);

    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 4'd7, 32'h0, 32'h77, 32'h10C);
    bus.regwrite_w = 1'b1; bus.rdw = 4'd4; bus.result_w = 32'hDEADBEEF;
    tick();
    chk("byp_rd1_e", bus.rd1_e, 32'hDEADBEEF);
    chk("byp_rd2_e", bus.rd2_e, 32'h77);
    bus.regwrite_w = 1'b0;

    bus.out_ready = 1'b0;
    set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 4'd9, 32'hA1, 32'hA2, 32'h200);
    #1 chk("bp_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", bus.out_valid, 1'b1);
      chk("bp_hold_rd1_e", bus.rd1_e, 32'hDEADBEEF);
      chk("bp_hold_pc_e", bus.pc_e, 32'h10C);
      chk("bp_hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_rel_in_ready", bus.in_ready, 1'b1);
    tick();
    chk("bp_rel_valid", bus.out_valid, 1'b1);
    chk("bp_rel_rd1_e", bus.rd1_e, 32'hA1);
    chk("bp_rel_pc_e", bus.pc_e, 32'h200);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_no_dup", bus.out_valid, 1'b0);

    set_instr(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 4'd2, 32'h5, 32'h6, 32'h300);
    tick();
    chk("st_memwrite_e", bus.memwrite_e, 1'b1);
    set_instr(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 4'd4, 32'h7, 32'h8, 32'h304);
    bus.flush = 1'b1; bus.out_ready = 1'b0;
    #1 chk("fl_in_ready", bus.in_ready, 1'b1);
    tick();
    chk("fl_out_valid", bus.out_valid, 1'b0);
    chk("fl_memwrite_e", bus.memwrite_e, 1'b0);
    chk("fl_stall_cnt", bus.stall_cnt, 2'd1);
    bus.flush = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      set_instr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd5, 32'h40, 32'h0, 32'h400);
      tick();
      set_instr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd6, 32'h55, 32'h66, 32'h404);
      tick();
      chk("sat_bubble_valid", bus.out_valid, 1'b0);
      chk("sat_stall_cnt", bus.stall_cnt, (i == 0) ? 2'd2 : 2'd3);
      tick();
      chk("sat_use_valid", bus.out_valid, 1'b1);
    end

    chk("pre_rst_valid", bus.out_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 1'b0);
    chk("arst_stall_cnt", bus.stall_cnt, 2'd0);
    chk("arst_rd1_e", bus.rd1_e, 32'h0);
    chk("arst_regwrite_e", bus.regwrite_e, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_ex_pipe.md
Name: decode_ex_pipe

Overview:
- Parametrised ID/EX pipeline stage for the RIDA CPU.
- Sits between the decode logic (control unit, register file, sign extend) and the execute cycle.
- Adds behaviour the fixed-width decode register lacks:
  - valid/ready handshake with backpressure;
  - synchronous flush;
  - write-back bypass into the operand capture;
  - load-use hazard detection with one-bubble insertion and a saturating stall counter.

Parameters:
DATA_W, 32, datapath width of operands, immediate, PC
REG_AW, 4, register address width (Rd/Rn fields)
ALUC_W, 3, ALU control width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
in_valid  in  1  decode holds a valid instruction
in_ready  out  1  stage accepts decode this cycle
flush  in  1  kill younger instructions (branch taken)
regwrite_d, alusrc_d, memwrite_d, resultsrc_d, branch_d  in  1 each  decoded control
alucontrol_d  in  ALUC_W  decoded ALU op
use_rn_d, use_rd_d  in  1 each  instruction reads Rn / Rd
rd1_d, rd2_d, imm_d, pc_d, pcplus4_d  in  DATA_W each  decode operands
rn_d, rd_d  in  REG_AW each  source/dest addresses
regwrite_w  in  1  write-back enable
rdw  in  REG_AW  write-back address
result_w  in  DATA_W  write-back data
out_valid  out  1  execute holds a valid instruction
out_ready  in  1  execute accepts
regwrite_e, alusrc_e, memwrite_e, resultsrc_e, branch_e  out  1 each
alucontrol_e  out  ALUC_W
rd1_e, rd2_e, imm_e, pc_e, pcplus4_e  out  DATA_W each
rs1_e, rs2_e, rd_e  out  REG_AW each  (rs1=Rn, rs2=Rd, rd=Rd)
stall_cnt  out  CNT_W  load-use bubbles inserted

Behaviour:
- Reset:
  - Asserting rst=0 clears every register immediately, regardless of clk.
  - out_valid=0, all *_e outputs 0, stall_cnt=0.
- Load condition: load_en = out_ready | ~out_valid.
- Hazard condition:
  - hazard = in_valid & out_valid & regwrite_e & resultsrc_e & ((use_rn_d & rd_e==rn_d) | (use_rd_d & rd_e==rd_d)).
  - A load sitting in execute whose destination is read by decode triggers it.
- in_ready:
  - flush: in_ready = 1.
  - Otherwise: in_ready = load_en & ~hazard.
  - in_ready is combinational; it never depends on in_valid except through hazard.
- Per-cycle priority, evaluated at the clk edge:
  1. flush=1: out_valid<=0; the input is consumed and discarded; stall_cnt unchanged.
  2. load_en & hazard: bubble. out_valid<=0, input not consumed, stall_cnt<=stall_cnt+1, saturating at all-ones.
  3. load_en & in_valid: capture all *_d into *_e and set out_valid<=1.
  4. load_en & ~in_valid: out_valid<=0.
  5. ~load_en: hold all registers (backpressure).
- Capture details:
  - rd1_e <= (regwrite_w & rdw==rn_d) ? result_w : rd1_d.
  - rd2_e <= (regwrite_w & rdw==rd_d) ? result_w : rd2_d.
  - This is the write-back bypass for the same-cycle register file write.
- Output gating:
  - regwrite_e, memwrite_e and branch_e read 0 whenever out_valid=0.
  - A bubble or flushed slot therefore never writes a register or memory, and never branches.
  - Gating uses the stored control bits ANDed with out_valid; the stored bits themselves are kept.
- Latency and throughput: latency 1 cycle from accept to out_valid; throughput 1 instruction/cycle with no hazard.
- A load-use pair costs exactly 1 bubble. After the bubble, out_valid=0, so hazard clears and the instruction is accepted on the next load_en.
- Flush during backpressure (~load_en): flush still wins and clears out_valid. Execute is expected to drop its handshake on flush.
- Reset mid-operation: the in-flight instruction is lost and stall_cnt returns to 0.
- Width rule: all address compares are full REG_AW bits; no register is treated as hardwired zero.

Test Plan:
- Reset, then a single ADD (regwrite_d=1, rn_d=2, rd_d=3, rd1_d=0x11, rd2_d=0x22, in_valid=1): next cycle out_valid=1, rd1_e=0x11, rd2_e=0x22, rs1_e=2, rd_e=3.
- Load-use: a load with rd_d=5, resultsrc_d=1 accepted, then an ADD with rn_d=5, use_rn_d=1:
  - in_ready=0 for 1 cycle, out_valid=0 with regwrite_e=0, stall_cnt=1;
  - the ADD appears the following cycle.
- Bypass: present rn_d=4, rd1_d=0x0, with regwrite_w=1, rdw=4, result_w=0xDEADBEEF in the capture cycle -> rd1_e=0xDEADBEEF.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, all *_e held constant, no instruction lost or duplicated on release.
- Flush: flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0, memwrite_e=0, in_ready was 1, stall_cnt unchanged.
- Saturation and reset: with CNT_W=2, 5 hazard bubbles -> stall_cnt=3. Drop rst mid-stream without a clock edge -> out_valid=0 and stall_cnt=0 immediately.
